// File: rtl/fir_pkg.sv
// Shared types and width helpers for the parametrised FIR core.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Full-precision sum width: product width plus growth over NTAPS terms
    function automatic int full_w(input int xw, input int cw, input int n);
        return xw + cw + clog2(n);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient shift register with burst-length counter and sticky error flag.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int C_W   = 6,
    parameter int NTAPS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               load_exit,
    input  logic [C_W-1:0]     coef_in,
    output logic [NTAPS*C_W-1:0] taps,
    output logic               coef_err
);

    localparam int CNT_W = clog2(NTAPS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NTAPS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NTAPS + 1);

    logic [C_W-1:0]   taps_q [NTAPS];
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) taps_q[i] <= '0;
            taps_q[0] <= C_W'(1);
            count_q   <= '0;
            coef_err  <= 1'b0;
        end else begin
            if (shift_en) begin
                for (int i = 0; i < NTAPS - 1; i++) taps_q[i] <= taps_q[i+1];
                taps_q[NTAPS-1] <= coef_in;
                if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
            end
            // Partial bursts leave taps as shifted; only the flag records it
            if (load_exit) begin
                count_q <= '0;
                if (count_q != CNT_FULL) coef_err <= 1'b1;
            end
        end
    end

    always_comb begin
        taps = '0;
        for (int i = 0; i < NTAPS; i++) taps[i*C_W +: C_W] = taps_q[i];
    end

endmodule

// File: rtl/fir_param_core.sv
// Direct-form FIR with serial coefficient reload and registered, narrowed output.
module fir_param_core
    import fir_pkg::*;
#(
    parameter int X_W       = 8,
    parameter int C_W       = 6,
    parameter int NTAPS     = 4,
    parameter int Y_W       = 16,
    parameter int OUT_SHIFT = 0,
    parameter bit SATURATE  = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] x_n,
    input  logic           x_valid,
    output logic           x_ready,
    input  logic [C_W-1:0] coef_in,
    input  logic           coef_load,
    output logic [Y_W-1:0] y_n,
    output logic           y_valid,
    output logic           coef_err
);

    localparam int FULL_W = full_w(X_W, C_W, NTAPS);
    localparam int SH_W   = FULL_W - OUT_SHIFT;

    state_t state_q, state_d;
    logic   accept;
    logic   load_exit;

    logic [NTAPS*C_W-1:0]   taps;
    logic signed [X_W-1:0]  d_q [NTAPS-1];
    logic signed [X_W-1:0]  xs [NTAPS];
    logic signed [C_W-1:0]  tk [NTAPS];
    logic signed [FULL_W-1:0] sum;
    logic signed [FULL_W-1:0] shifted;
    logic [Y_W-1:0]         y_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        x_ready   = ~coef_load & (state_q != LOAD);
        load_exit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (coef_load)    state_d = LOAD;
                else if (x_valid) state_d = RUN;
            end
            RUN: begin
                if (coef_load) state_d = LOAD;
            end
            LOAD: begin
                if (!coef_load) begin
                    state_d   = IDLE;
                    load_exit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        accept = x_valid & x_ready;
    end

    fir_coef_bank #(
        .C_W   (C_W),
        .NTAPS (NTAPS)
    ) u_coef_bank (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (coef_load),
        .load_exit (load_exit),
        .coef_in   (coef_in),
        .taps      (taps),
        .coef_err  (coef_err)
    );

    // History is cleared on leaving LOAD so new taps never see stale samples
    always_ff @(posedge clk) begin
        if (reset || load_exit) begin
            for (int i = 0; i < NTAPS - 1; i++) d_q[i] <= '0;
        end else if (accept) begin
            d_q[0] <= x_n;
            for (int i = 1; i < NTAPS - 1; i++) d_q[i] <= d_q[i-1];
        end
    end

    always_comb begin
        xs[0] = x_n;
        for (int k = 1; k < NTAPS; k++) xs[k] = d_q[k-1];
        sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            tk[k] = taps[k*C_W +: C_W];
            sum   = sum + FULL_W'(tk[k]) * FULL_W'(xs[k]);
        end
        shifted = sum >>> OUT_SHIFT;
    end

    generate
        if (Y_W >= SH_W) begin : g_ext
            assign y_d = Y_W'(shifted);
        end else if (SATURATE) begin : g_sat
            localparam logic signed [FULL_W-1:0] Y_MAX =
                {{(FULL_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
            localparam logic signed [FULL_W-1:0] Y_MIN =
                {{(FULL_W-Y_W+1){1'b1}}, {(Y_W-1){1'b0}}};
            always_comb begin
                if (shifted > Y_MAX)      y_d = Y_MAX[Y_W-1:0];
                else if (shifted < Y_MIN) y_d = Y_MIN[Y_W-1:0];
                else                      y_d = shifted[Y_W-1:0];
            end
        end else begin : g_wrap
            assign y_d = shifted[Y_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            y_n     <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= accept;
            if (accept) y_n <= y_d;
        end
    end

endmodule

// File: tb/tb_fir_param_core.sv
// Directed bench for fir_param_core: default build plus 8-bit saturating and wrapping builds.
module tb_fir_param_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  x_n = '0;
    logic        x_valid = 1'b0;
    logic [5:0]  coef_in = '0;
    logic        coef_load = 1'b0;

    logic        x_ready, y_valid, coef_err;
    logic [15:0] y_n;
    logic        x_ready_s, y_valid_s, coef_err_s;
    logic [7:0]  y_n_s;
    logic        x_ready_w, y_valid_w, coef_err_w;
    logic [7:0]  y_n_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_param_core #(.Y_W(16), .SATURATE(1'b1)) dut (
        .clk(clk), .reset(reset), .x_n(x_n), .x_valid(x_valid),
        .x_ready(x_ready), .coef_in(coef_in), .coef_load(coef_load),
        .y_n(y_n), .y_valid(y_valid), .coef_err(coef_err)
    );

    fir_param_core #(.Y_W(8), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .x_n(x_n), .x_valid(x_valid),
        .x_ready(x_ready_s), .coef_in(coef_in), .coef_load(coef_load),
        .y_n(y_n_s), .y_valid(y_valid_s), .coef_err(coef_err_s)
    );

    fir_param_core #(.Y_W(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .x_n(x_n), .x_valid(x_valid),
        .x_ready(x_ready_w), .coef_in(coef_in), .coef_load(coef_load),
        .y_n(y_n_w), .y_valid(y_valid_w), .coef_err(coef_err_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Stimulus only: shift n words (w0 first), then drop coef_load for the exit cycle
    task automatic do_load(input int n, input logic [5:0] w0, input logic [5:0] w1,
                           input logic [5:0] w2, input logic [5:0] w3);
        logic [5:0] w [4];
        w = '{w0, w1, w2, w3};
        x_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            coef_load = 1'b1;
            coef_in = w[i];
            step();
        end
        coef_load = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (y_n !== 16'd0) begin
            failures++;
            $display("FAIL reset_y_n got=%0h want=0", y_n);
        end
        checks++;
        if (y_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_y_valid got=%b want=0", y_valid);
        end
        checks++;
        if (coef_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_coef_err got=%b want=0", coef_err);
        end
        checks++;
        if (x_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_x_ready got=%b want=1", x_ready);
        end
    endtask

    task automatic test_passthrough();
        int xs [3] = '{5, -7, 100};
        for (int i = 0; i < 3; i++) begin
            x_n = 8'(xs[i]);
            x_valid = 1'b1;
            checks++;
            if (x_ready !== 1'b1) begin
                failures++;
                $display("FAIL pass_x_ready[%0d] got=%b want=1", i, x_ready);
            end
            step();
            checks++;
            if (y_valid !== 1'b1 || y_n !== 16'(xs[i])) begin
                failures++;
                $display("FAIL pass_y[%0d] got=%0d/v%b want=%0d/v1",
                         i, $signed(y_n), y_valid, xs[i]);
            end
        end
        x_valid = 1'b0;
        step();
        checks++;
        if (y_valid !== 1'b0 || y_n !== 16'd100) begin
            failures++;
            $display("FAIL pass_hold got=%0d/v%b want=100/v0", $signed(y_n), y_valid);
        end
    endtask

    task automatic test_impulse();
        int xs [5] = '{1, 0, 0, 0, 0};
        int ys [5] = '{1, 2, 3, 4, 0};
        do_load(4, 6'd1, 6'd2, 6'd3, 6'd4);
        checks++;
        if (coef_err !== 1'b0) begin
            failures++;
            $display("FAIL impulse_coef_err got=%b want=0", coef_err);
        end
        for (int i = 0; i < 5; i++) begin
            x_n = 8'(xs[i]);
            x_valid = 1'b1;
            step();
            checks++;
            if (y_valid !== 1'b1 || y_n !== 16'(ys[i])) begin
                failures++;
                $display("FAIL impulse_y[%0d] got=%0d/v%b want=%0d/v1",
                         i, $signed(y_n), y_valid, ys[i]);
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_bad_load();
        do_load(3, 6'd5, 6'd6, 6'd7, 6'd0);
        checks++;
        if (coef_err !== 1'b1) begin
            failures++;
            $display("FAIL short_load_err got=%b want=1", coef_err);
        end
        do_load(4, 6'd1, 6'd2, 6'd3, 6'd4);
        checks++;
        if (coef_err !== 1'b1) begin
            failures++;
            $display("FAIL sticky_err got=%b want=1", coef_err);
        end
        x_n = 8'd1;
        x_valid = 1'b1;
        step();
        x_n = 8'd0;
        step();
        x_valid = 1'b0;
        checks++;
        if (y_n !== 16'd2) begin
            failures++;
            $display("FAIL reload_taps got=%0d want=2", $signed(y_n));
        end
        do_reset();
        checks++;
        if (coef_err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared got=%b want=0", coef_err);
        end
    endtask

    task automatic test_collision();
        int xs [3] = '{10, 20, 30};
        for (int i = 0; i < 3; i++) begin
            x_n = 8'(xs[i]);
            x_valid = 1'b1;
            step();
        end
        x_n = 8'd99;
        coef_load = 1'b1;
        coef_in = 6'd1;
        #1;
        checks++;
        if (x_ready !== 1'b0) begin
            failures++;
            $display("FAIL collide_x_ready got=%b want=0", x_ready);
        end
        step();
        checks++;
        if (y_valid !== 1'b0) begin
            failures++;
            $display("FAIL collide_y_valid got=%b want=0", y_valid);
        end
        x_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        coef_load = 1'b0;
        step();
        checks++;
        if (coef_err !== 1'b0) begin
            failures++;
            $display("FAIL collide_err got=%b want=0", coef_err);
        end
        x_n = 8'd2;
        x_valid = 1'b1;
        step();
        checks++;
        if (y_n !== 16'd2) begin
            failures++;
            $display("FAIL flush_first got=%0d want=2", $signed(y_n));
        end
        x_n = 8'd3;
        step();
        x_valid = 1'b0;
        checks++;
        if (y_n !== 16'd5) begin
            failures++;
            $display("FAIL flush_second got=%0d want=5", $signed(y_n));
        end
    endtask

    task automatic test_saturate();
        do_load(4, 6'd31, 6'd31, 6'd31, 6'd31);
        checks++;
        if (coef_err_w !== 1'b0 || x_ready_s !== 1'b1) begin
            failures++;
            $display("FAIL sat_load got=%b/%b want=0/1", coef_err_w, x_ready_s);
        end
        x_n = 8'd127;
        x_valid = 1'b1;
        step();
        checks++;
        if (y_n_s !== 8'd127 || y_n_w !== 8'h61 || y_n !== 16'd3937) begin
            failures++;
            $display("FAIL pos_first got=%0h/%0h/%0h want=7f/61/f61", y_n_s, y_n_w, y_n);
        end
        step();
        step();
        step();
        x_valid = 1'b0;
        checks++;
        if (y_n_s !== 8'd127 || y_n_w !== 8'h84 || y_n !== 16'h3d84
            || y_valid_s !== 1'b1 || y_valid_w !== 1'b1) begin
            failures++;
            $display("FAIL pos_full got=%0h/%0h/%0h want=7f/84/3d84", y_n_s, y_n_w, y_n);
        end
        do_load(4, 6'd31, 6'd31, 6'd31, 6'd31);
        x_n = 8'h80;
        x_valid = 1'b1;
        step();
        checks++;
        if (y_n_s !== 8'h80 || y_n_w !== 8'h80 || y_n !== 16'hf080) begin
            failures++;
            $display("FAIL neg_first got=%0h/%0h/%0h want=80/80/f080", y_n_s, y_n_w, y_n);
        end
        step();
        step();
        step();
        x_valid = 1'b0;
        checks++;
        if (y_n_s !== 8'h80 || y_n_w !== 8'h00 || y_n !== 16'hc200 || coef_err_s !== 1'b0) begin
            failures++;
            $display("FAIL neg_full got=%0h/%0h/%0h want=80/00/c200", y_n_s, y_n_w, y_n);
        end
    endtask

    task automatic test_reset_midop();
        coef_load = 1'b1;
        coef_in = 6'd7;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        coef_load = 1'b0;
        #1;
        checks++;
        if (y_n !== 16'd0 || y_valid !== 1'b0 || coef_err !== 1'b0 || x_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_load got=y%0h v%b e%b r%b want=y0 v0 e0 r1",
                     y_n, y_valid, coef_err, x_ready);
        end
        x_n = 8'd11;
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        checks++;
        if (y_n !== 16'd11 || y_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_load_taps got=%0d want=11", $signed(y_n));
        end
        do_load(4, 6'd1, 6'd1, 6'd1, 6'd1);
        x_n = 8'd4;
        x_valid = 1'b1;
        step();
        x_n = 8'd5;
        step();
        checks++;
        if (y_n !== 16'd9) begin
            failures++;
            $display("FAIL run_sum got=%0d want=9", $signed(y_n));
        end
        x_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (y_n !== 16'd0 || y_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_run got=%0h/v%b want=0/v0", y_n, y_valid);
        end
        x_n = 8'd6;
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        checks++;
        if (y_n !== 16'd6) begin
            failures++;
            $display("FAIL rst_run_taps got=%0d want=6", $signed(y_n));
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_impulse();
        test_bad_load();
        test_collision();
        test_saturate();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
